draw_text_layer: RTL and testbench

Parametrised text-overlay stage for the VGA pipeline. It generalises the fixed power-of-two glyph renderer in four ways: integer glyph scaling (1..8), a runtime text-window position that updates only at frame boundaries, an optional background fill, and frame-counted blinking. It sits in series on the VGA bus between the background/sprite stages and the output stage, and drives an external char-code/font ROM lookup.

---
 rtl/draw_text_layer.sv | 223 ++++++++++++++++++++++
 tb/tb_draw_text_layer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_text_layer.sv
// draw_text_layer: scaled, frame-positioned, optionally blinking text overlay
// on the VGA bus. Drives a char-code/font ROM lookup and recolours rgb three
// clocks later using the registered ROM glyph row.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 36
`endif

module draw_text_layer #(
  parameter logic [11:0] TEXT_COLOUR  = 12'h0_2_9,
  parameter logic [11:0] BG_COLOUR    = 12'h0_0_0,
  parameter bit          BG_EN        = 1'b0,
  parameter int unsigned SCALE        = 1,
  parameter int unsigned TEXT_SIZE_X  = 16,
  parameter int unsigned TEXT_SIZE_Y  = 16,
  parameter logic [10:0] TEXT_POS_X   = 11'd50,
  parameter logic [10:0] TEXT_POS_Y   = 11'd50,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned XW = $clog2(TEXT_SIZE_X),
  localparam int unsigned YW = $clog2(TEXT_SIZE_Y)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     text_en,
  input  logic                     blink_en,
  input  logic [10:0]              pos_x,
  input  logic [10:0]              pos_y,
  input  logic [7:0]               char_pixels,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic [XW-1:0]            char_x,
  output logic [YW-1:0]            char_y,
  output logic [3:0]               char_line
);

  // Bus layout (MSB..LSB): hcount[10:0], hsync, vcount[10:0], vsync, rgb[11:0]
  localparam int unsigned W       = 8 * TEXT_SIZE_X * SCALE;
  localparam logic [13:0] W14     = 14'(W);
  localparam logic [2:0]  SX_MAX  = 3'(SCALE - 1);
  localparam logic [YW-1:0] ROW_MAX = YW'(TEXT_SIZE_Y - 1);
  localparam logic [7:0]  CNT_MAX = 8'(BLINK_FRAMES - 1);

  logic [10:0] hcount_in, vcount_in;
  logic [11:0] rgb2;
  assign hcount_in = vga_bus_in[35:25];
  assign vcount_in = vga_bus_in[23:13];

  // Frame-latched window position and blink state
  logic [10:0] px_q, py_q;
  logic [7:0]  cnt_q;
  logic        phase_q;

  // Horizontal counters (sub-pixel, bit, column)
  logic [2:0]    sx_q, sx_cur, sx_d;
  logic [2:0]    bit_q, bit_cur, bit_d;
  logic [XW-1:0] col_q, col_cur, col_d;

  // Vertical counters (sub-line, glyph line, row) and vertical window flag
  logic [2:0]    sy_q, sy_cur;
  logic [3:0]    ln_q, ln_cur;
  logic [YW-1:0] row_q, row_cur;
  logic          vv_q, vv_cur;

  // Pipeline registers
  logic [`VGA_BUS_SIZE-1:0] bus1_q, bus2_q, bus_out_q;
  logic                     win1_q, win2_q;
  logic [2:0]               bit1_q, bit2_q;
  logic                     ph1_q, ph2_q;
  logic [XW-1:0]            char_x_q;
  logic [YW-1:0]            char_y_q;
  logic [3:0]               char_line_q;

  logic        frame_start, line_start, v_hit, v_last, h_clr, h_in, in_win;
  logic        phase_cur;
  logic [10:0] px_eff, py_eff;
  logic [11:0] rgb_out;
  logic        glyph;

  // The frame-start pixel already uses the newly requested position
  always_comb begin
    frame_start = (hcount_in == '0) && (vcount_in == '0);
    line_start  = (hcount_in == '0);
    px_eff      = frame_start ? pos_x : px_q;
    py_eff      = frame_start ? pos_y : py_q;
    v_hit       = line_start && (vcount_in == py_eff);
    h_clr       = (hcount_in == px_eff);
    h_in        = ({3'b000, hcount_in} >= {3'b000, px_eff}) &&
                  ({3'b000, hcount_in} <  ({3'b000, px_eff} + W14));
    phase_cur   = (frame_start && (cnt_q == CNT_MAX)) ? ~phase_q : phase_q;
  end

  // Horizontal counters: value for the current pixel, and advance for the next
  always_comb begin
    sx_cur  = sx_q;
    bit_cur = bit_q;
    col_cur = col_q;
    if (h_clr) begin
      sx_cur  = '0;
      bit_cur = '0;
      col_cur = '0;
    end
    sx_d  = sx_cur + 3'd1;
    bit_d = bit_cur;
    col_d = col_cur;
    if (sx_cur == SX_MAX) begin
      sx_d  = '0;
      bit_d = bit_cur + 3'd1;
      if (bit_cur == 3'd7) col_d = col_cur + XW'(1);
    end
  end

  // Vertical counters step once per line; v_valid opens on the py line only
  always_comb begin
    sy_cur  = sy_q;
    ln_cur  = ln_q;
    row_cur = row_q;
    vv_cur  = vv_q;
    v_last  = (sy_q == SX_MAX) && (ln_q == 4'd15) && (row_q == ROW_MAX);
    if (v_hit) begin
      sy_cur  = '0;
      ln_cur  = '0;
      row_cur = '0;
      vv_cur  = 1'b1;
    end else if (line_start) begin
      if (frame_start || v_last) vv_cur = 1'b0;
      if (sy_q == SX_MAX) begin
        sy_cur = '0;
        if (ln_q == 4'd15) begin
          ln_cur  = '0;
          row_cur = row_q + YW'(1);
        end else begin
          ln_cur = ln_q + 4'd1;
        end
      end else begin
        sy_cur = sy_q + 3'd1;
      end
    end
    in_win = h_in && vv_cur;
  end

  // Frame-level state: position latch and blink frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q    <= TEXT_POS_X;
      py_q    <= TEXT_POS_Y;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (frame_start) begin
      px_q    <= pos_x;
      py_q    <= pos_y;
      cnt_q   <= (cnt_q == CNT_MAX) ? 8'd0 : cnt_q + 8'd1;
      phase_q <= phase_cur;
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q  <= '0;
      bit_q <= '0;
      col_q <= '0;
      sy_q  <= '0;
      ln_q  <= '0;
      row_q <= '0;
      vv_q  <= 1'b0;
    end else begin
      sx_q  <= sx_d;
      bit_q <= bit_d;
      col_q <= col_d;
      sy_q  <= sy_cur;
      ln_q  <= ln_cur;
      row_q <= row_cur;
      vv_q  <= vv_cur;
    end
  end

  // Output-stage pixel decision using the registered ROM row
  always_comb begin
    rgb2    = bus2_q[11:0];
    glyph   = text_en && char_pixels[3'd7 - bit2_q] && (!blink_en || !ph2_q);
    rgb_out = rgb2;
    if (win2_q) begin
      if (glyph)      rgb_out = TEXT_COLOUR;
      else if (BG_EN) rgb_out = BG_COLOUR;
    end
  end

  // Three-stage bus pipeline with the window flag and bit index carried along
  always_ff @(posedge clk) begin
    if (rst) begin
      bus1_q      <= '0;
      bus2_q      <= '0;
      bus_out_q   <= '0;
      win1_q      <= 1'b0;
      win2_q      <= 1'b0;
      bit1_q      <= '0;
      bit2_q      <= '0;
      ph1_q       <= 1'b0;
      ph2_q       <= 1'b0;
      char_x_q    <= '0;
      char_y_q    <= '0;
      char_line_q <= '0;
    end else begin
      bus1_q      <= vga_bus_in;
      win1_q      <= in_win;
      bit1_q      <= bit_cur;
      ph1_q       <= phase_cur;
      char_x_q    <= in_win ? col_cur : '0;
      char_y_q    <= in_win ? row_cur : '0;
      char_line_q <= in_win ? ln_cur  : '0;
      bus2_q      <= bus1_q;
      win2_q      <= win1_q;
      bit2_q      <= bit1_q;
      ph2_q       <= ph1_q;
      bus_out_q   <= {bus2_q[35:12], rgb_out};
    end
  end

  assign vga_bus_out = bus_out_q;
  assign char_x      = char_x_q;
  assign char_y      = char_y_q;
  assign char_line   = char_line_q;

endmodule

// File: tb/tb_draw_text_layer.sv
// Scoreboard bench for draw_text_layer: two instances (scaled with background
// fill, unscaled passthrough) driven by a compact raster with random rgb and
// random position requests; expectations come from a geometric reference model.
`timescale 1ns/1ps

module tb_draw_text_layer;

  localparam int HT = 80;
  localparam int VT = 110;
  localparam int NF = 8;
  localparam int RST_FRAME = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        text_en, blink_en;
  logic [10:0] pos_x, pos_y;
  logic [35:0] bus_in;
  logic [35:0] bus_out_a, bus_out_b;
  logic [0:0]  cx_a, cy_a;
  logic [1:0]  cx_b, cy_b;
  logic [3:0]  ln_a, ln_b;
  logic [7:0]  pix_a, pix_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int rom_mode = 0;

  // Reference-model state
  int m_px, m_py, m_cnt;
  bit m_phase, m_vseen;

  typedef struct { int due; logic [35:0] b0; logic [35:0] b1; } bus_item_t;
  typedef struct { int due; int cx0; int cy0; int ln0; int cx1; int cy1; int ln1; } chr_item_t;
  bus_item_t bq[$];
  chr_item_t cq[$];

  draw_text_layer #(
    .TEXT_COLOUR(12'hF80), .BG_COLOUR(12'h123), .BG_EN(1'b1), .SCALE(3),
    .TEXT_SIZE_X(2), .TEXT_SIZE_Y(2), .TEXT_POS_X(11'd20), .TEXT_POS_Y(11'd5),
    .BLINK_FRAMES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .text_en(text_en), .blink_en(blink_en),
    .pos_x(pos_x), .pos_y(pos_y), .char_pixels(pix_a), .vga_bus_in(bus_in),
    .vga_bus_out(bus_out_a), .char_x(cx_a), .char_y(cy_a), .char_line(ln_a)
  );

  draw_text_layer #(
    .TEXT_COLOUR(12'h029), .BG_COLOUR(12'h000), .BG_EN(1'b0), .SCALE(1),
    .TEXT_SIZE_X(4), .TEXT_SIZE_Y(4), .TEXT_POS_X(11'd20), .TEXT_POS_Y(11'd5),
    .BLINK_FRAMES(2)
  ) dut_b (
    .clk(clk), .rst(rst), .text_en(text_en), .blink_en(blink_en),
    .pos_x(pos_x), .pos_y(pos_y), .char_pixels(pix_b), .vga_bus_in(bus_in),
    .vga_bus_out(bus_out_b), .char_x(cx_b), .char_y(cy_b), .char_line(ln_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input int mode, input int inst, input int cx,
                                     input int cy, input int ln);
    int t;
    case (mode)
      0: return 8'hA5;
      1: return 8'hFF;
      2: return 8'h00;
      default: begin
        t = (cx * 53 + cy * 29 + ln * 17 + inst * 7) ^ 'h5C;
        return t[7:0];
      end
    endcase
  endfunction

  // Registered font ROM: row is valid the cycle after the char address
  always @(posedge clk) begin
    pix_a <= rom(rom_mode, 0, int'(cx_a), int'(cy_a), int'(ln_a));
    pix_b <= rom(rom_mode, 1, int'(cx_b), int'(cy_b), int'(ln_b));
  end

  function automatic void model(input int inst, input int h, input int v,
                                input logic [11:0] rgb_in, output int cx,
                                output int cy, output int ln, output logic [11:0] rgb_o);
    int s, w, hh, k, r, bitn;
    logic [7:0] row;
    logic inwin, glyph;
    s  = (inst == 0) ? 3 : 1;
    w  = 8 * ((inst == 0) ? 2 : 4) * s;
    hh = 16 * ((inst == 0) ? 2 : 4) * s;
    inwin = (h >= m_px) && (h < m_px + w) && m_vseen && (v >= m_py) && (v < m_py + hh);
    cx = 0; cy = 0; ln = 0;
    rgb_o = rgb_in;
    if (inwin) begin
      k = h - m_px;
      r = v - m_py;
      cx = k / (8 * s);
      bitn = (k / s) % 8;
      ln = (r / s) % 16;
      cy = r / (16 * s);
      row = rom(rom_mode, inst, cx, cy, ln);
      glyph = text_en && row[7 - bitn] && (!blink_en || !m_phase);
      if (glyph) rgb_o = (inst == 0) ? 12'hF80 : 12'h029;
      else if (inst == 0) rgb_o = 12'h123;
    end
  endfunction

  function automatic void model_reset();
    m_px = 20; m_py = 5; m_cnt = 0; m_phase = 1'b0; m_vseen = 1'b0;
  endfunction

  // Monitor: compare every output that falls due on this cycle
  always @(negedge clk) begin
    while (cq.size() > 0 && cq[0].due == cyc) begin
      n_cmp++;
      if (int'(cx_a) != cq[0].cx0 || int'(cy_a) != cq[0].cy0 || int'(ln_a) != cq[0].ln0) begin
        n_fail++;
        $display("FAIL char_a cyc=%0d got x=%0d y=%0d l=%0d want x=%0d y=%0d l=%0d",
                 cyc, cx_a, cy_a, ln_a, cq[0].cx0, cq[0].cy0, cq[0].ln0);
      end
      n_cmp++;
      if (int'(cx_b) != cq[0].cx1 || int'(cy_b) != cq[0].cy1 || int'(ln_b) != cq[0].ln1) begin
        n_fail++;
        $display("FAIL char_b cyc=%0d got x=%0d y=%0d l=%0d want x=%0d y=%0d l=%0d",
                 cyc, cx_b, cy_b, ln_b, cq[0].cx1, cq[0].cy1, cq[0].ln1);
      end
      void'(cq.pop_front());
    end
    while (bq.size() > 0 && bq[0].due == cyc) begin
      n_cmp++;
      if (bus_out_a !== bq[0].b0) begin
        n_fail++;
        $display("FAIL bus_a cyc=%0d got %h want %h", cyc, bus_out_a, bq[0].b0);
      end
      n_cmp++;
      if (bus_out_b !== bq[0].b1) begin
        n_fail++;
        $display("FAIL bus_b cyc=%0d got %h want %h", cyc, bus_out_b, bq[0].b1);
      end
      void'(bq.pop_front());
    end
  end

  initial begin
    int cx0, cy0, ln0, cx1, cy1, ln1;
    logic [11:0] rgb, r0, r1;
    logic hs, vs, rst_v;
    bit rst_done;
    rst = 1'b1;
    text_en = 1'b1;
    blink_en = 1'b0;
    pos_x = 11'd20;
    pos_y = 11'd5;
    bus_in = '0;
    rst_done = 1'b0;
    model_reset();

    for (int f = 0; f < NF; f++) begin
      for (int v = 0; v < VT; v++) begin
        for (int h = 0; h < HT; h++) begin
          @(negedge clk);
          if (h == 0 && v == 0) begin
            case (f)
              0:       begin rom_mode = 0; text_en = 1'b1; blink_en = 1'b0; end
              1:       begin rom_mode = 3; text_en = 1'b1; blink_en = 1'b0; end
              2, 3, 4: begin rom_mode = 1; text_en = 1'b1; blink_en = 1'b1; end
              5:       begin rom_mode = 2; text_en = 1'b0; blink_en = 1'b0; end
              default: begin rom_mode = 3; text_en = 1'b1; blink_en = 1'b0; end
            endcase
          end
          if (h == 0 && $urandom_range(0, 7) == 0) begin
            pos_x = 11'($urandom_range(0, 60));
            pos_y = 11'($urandom_range(0, 12));
          end
          rst_v = (f == 0 && v == 0 && h < 3) ||
                  (f == RST_FRAME && !rst_done && v == m_py + 20 && h == m_px + 5);
          if (f == RST_FRAME && rst_v) rst_done = 1'b1;
          hs  = (h >= 64 && h < 70);
          vs  = (v >= 100 && v < 102);
          rgb = 12'($urandom);
          rst = rst_v;
          bus_in = {11'(h), hs, 11'(v), vs, rgb};

          if (rst_v) begin
            model_reset();
            while (bq.size() > 0 && bq[$].due > cyc) void'(bq.pop_back());
            for (int d = 1; d <= 3; d++) bq.push_back('{cyc + d, 36'h0, 36'h0});
            cq.push_back('{cyc + 1, 0, 0, 0, 0, 0, 0});
          end else begin
            if (h == 0 && v == 0) begin
              m_px = int'(pos_x);
              m_py = int'(pos_y);
              if (m_cnt == 1) begin
                m_cnt = 0;
                m_phase = ~m_phase;
              end else begin
                m_cnt = m_cnt + 1;
              end
            end
            if (h == 0 && v == m_py) m_vseen = 1'b1;
            model(0, h, v, rgb, cx0, cy0, ln0, r0);
            model(1, h, v, rgb, cx1, cy1, ln1, r1);
            cq.push_back('{cyc + 1, cx0, cy0, ln0, cx1, cy1, ln1});
            bq.push_back('{cyc + 3, {11'(h), hs, 11'(v), vs, r0},
                                    {11'(h), hs, 11'(v), vs, r1}});
          end
        end
      end
    end

    repeat (8) @(negedge clk);
    n_cmp++;
    if (bq.size() != 0 || cq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got bus=%0d char=%0d pending want 0", bq.size(), cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
